// File: rtl/assoc_cache_ctrl_if.sv
// CPU request channel and memory command/return channel of the set-associative cache.
// The cache takes the slave view; the requester/memory side takes the master view.
interface assoc_cache_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              stall;
  logic              hit;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_rvalid,
    output stall, hit, rdata, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_rvalid,
    input  stall, hit, rdata, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// Set-associative (1 or 2 way) write-through cache controller with read-miss block fill
// over a pipelined memory channel whose returns arrive in issue order.
module assoc_cache_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SETS   = 64,
  parameter int WORDS  = 8,
  parameter int WAYS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  assoc_cache_ctrl_if.slave     bus,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);
  localparam int WSEL_W = $clog2(WORDS);
  localparam int OFF    = WSEL_W + 1;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WAIT} state_t;

  state_t              state_q;
  logic [WSEL_W-1:0]   issue_q, recv_q;
  logic [TAG_W-1:0]    fill_tag_q;
  logic [IDX_W-1:0]    fill_idx_q;
  logic [WAY_W-1:0]    victim_q;
  logic [TAG_W-1:0]    tag_q   [WAYS][SETS];
  logic [SETS-1:0]     valid_q [WAYS];
  logic [SETS-1:0]     lru_q;
  logic [DATA_W-1:0]   data_q  [WAYS][SETS][WORDS];
  logic [15:0]         hit_cnt_q, miss_cnt_q, hit_cnt_d, miss_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_word;
  logic              unused_addr_lsb;

  assign req_tag         = bus.req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx         = bus.req_addr[OFF +: IDX_W];
  assign req_word        = bus.req_addr[1 +: WSEL_W];
  assign unused_addr_lsb = bus.req_addr[0];

  logic             hit_any;
  logic [WAY_W-1:0] hit_way, victim;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Invalid ways are filled lowest first; only a fully valid set consults LRU.
  always_comb begin
    victim = '0;
    if (WAYS == 2) begin
      if (!valid_q[0][req_idx])             victim = '0;
      else if (!valid_q[WAYS-1][req_idx])   victim = '1;
      else                                  victim = lru_q[req_idx];
    end
  end

  logic idle_req, wr_req, rd_miss, rx, last_rx;

  assign idle_req = (state_q == IDLE) && bus.req_valid;
  assign wr_req   = idle_req && bus.req_write;
  assign rd_miss  = idle_req && !bus.req_write && !hit_any;
  assign rx       = (state_q != IDLE) && bus.mem_rvalid;
  assign last_rx  = rx && (recv_q == WSEL_W'(WORDS - 1));

  assign hit_cnt_d  = sat_inc(hit_cnt_q,  idle_req && hit_any);
  assign miss_cnt_d = sat_inc(miss_cnt_q, idle_req && !hit_any);
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  logic              stall, hit, mem_en, mem_wr;
  logic [DATA_W-1:0] rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  always_comb begin
    stall     = 1'b0;
    hit       = 1'b0;
    rdata     = '0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_write) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = bus.req_addr;
            mem_wdata = bus.req_wdata;
            hit       = hit_any;
          end else if (hit_any) begin
            hit   = 1'b1;
            rdata = data_q[hit_way][req_idx][req_word];
          end else begin
            stall = 1'b1;
          end
        end
      end
      FILL: begin
        stall    = 1'b1;
        mem_en   = 1'b1;
        mem_addr = {fill_tag_q, fill_idx_q, issue_q, 1'b0};
      end
      WAIT:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign bus.stall     = stall;
  assign bus.hit       = hit;
  assign bus.rdata     = rdata;
  assign bus.mem_en    = mem_en;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      issue_q    <= '0;
      recv_q     <= '0;
      lru_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      case (state_q)
        IDLE: begin
          if (idle_req && hit_any) begin
            if (WAYS == 2) lru_q[req_idx] <= ~hit_way;
          end else if (rd_miss) begin
            state_q <= FILL;
            issue_q <= '0;
            recv_q  <= '0;
          end
        end
        FILL: begin
          issue_q <= issue_q + WSEL_W'(1);
          if (issue_q == WSEL_W'(WORDS - 1)) state_q <= WAIT;
        end
        default: ;
      endcase
      if (rx) recv_q <= recv_q + WSEL_W'(1);
      // The final return closes the fill regardless of whether issuing has finished.
      if (last_rx) begin
        state_q                      <= IDLE;
        valid_q[victim_q][fill_idx_q] <= 1'b1;
        if (WAYS == 2) lru_q[fill_idx_q] <= ~victim_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_miss) begin
      fill_tag_q <= req_tag;
      fill_idx_q <= req_idx;
      victim_q   <= victim;
    end
    if (wr_req && hit_any) data_q[hit_way][req_idx][req_word] <= bus.req_wdata;
    if (rx)                data_q[victim_q][fill_idx_q][recv_q] <= bus.mem_rdata;
    if (last_rx)           tag_q[victim_q][fill_idx_q] <= fill_tag_q;
  end
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl: 4-cycle memory model, fill-address scoreboard,
// counter model and immediate-assertion checks.
module tb_assoc_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hit_count, miss_count;

  assoc_cache_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  assoc_cache_ctrl #(.ADDR_W(16), .DATA_W(16), .SETS(64), .WORDS(8), .WAYS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int exp_hit  = 0;
  int exp_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: read data mem[a] = a ^ 0x5A5A, returned four cycles after issue.
  logic [3:0]  pv = '0;
  logic [15:0] pa [4];
  always @(posedge clk) begin
    pv    <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
    pa[0] <= bus.mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign bus.mem_rvalid = pv[3];
  assign bus.mem_rdata  = pa[3] ^ 16'h5A5A;

  // Scoreboard of expected fill read addresses, in issue order.
  logic [15:0] exp_q [$];
  always @(negedge clk) begin
    if (bus.mem_en && !bus.mem_wr) begin
      logic [15:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hFFFF;
      chk("fill_addr", bus.mem_addr, e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_miss(input logic [15:0] a, input logic [15:0] d);
    bit done;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    for (int k = 0; k < 8; k++) exp_q.push_back({a[15:4], 3'(k), 1'b0});
    @(negedge clk);
    chk("miss_stall", bus.stall, 1);
    chk("miss_hit", bus.hit, 0);
    exp_miss++;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      @(negedge clk);
      if (!bus.stall) done = 1'b1;
      else if (c == 2) begin
        chk("fill_hit", bus.hit, 0);
        chk("fill_rdata", bus.rdata, 0);
      end
    end
    chk("fill_done", done, 1);
    chk("refill_hit", bus.hit, 1);
    chk("refill_rdata", bus.rdata, d);
    exp_hit++;
    step();
    bus.req_valid = 1'b0;
    chk("miss_count", miss_count, exp_miss);
    chk("hit_count", hit_count, exp_hit);
  endtask

  task automatic read_hit(input logic [15:0] a, input logic [15:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    @(negedge clk);
    chk("rdhit_stall", bus.stall, 0);
    chk("rdhit_hit", bus.hit, 1);
    chk("rdhit_rdata", bus.rdata, d);
    chk("rdhit_mem_en", bus.mem_en, 0);
    exp_hit++;
    step();
    bus.req_valid = 1'b0;
    chk("hit_count", hit_count, exp_hit);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic h);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk);
    chk("wr_mem_en", bus.mem_en, 1);
    chk("wr_mem_wr", bus.mem_wr, 1);
    chk("wr_mem_addr", bus.mem_addr, a);
    chk("wr_mem_wdata", bus.mem_wdata, d);
    chk("wr_stall", bus.stall, 0);
    chk("wr_hit", bus.hit, h);
    if (h) exp_hit++;
    else   exp_miss++;
    step();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    chk("wr_hit_count", hit_count, exp_hit);
    chk("wr_miss_count", miss_count, exp_miss);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", bus.stall, 0);
    chk("rst_hit", bus.hit, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    step();
    rst = 1'b0;

    // Cold miss and fill of set 4 way 0
    read_miss(16'h0046, 16'h5A1C);
    // Second way of set 4, then LRU eviction of way 0
    read_miss(16'h0442, 16'h5E18);
    read_miss(16'h0842, 16'h5218);
    read_hit(16'h0442, 16'h5E18);
    read_miss(16'h0040, 16'h5A1A);

    // Write-through hit, then write-through miss with no allocate
    do_write(16'h0046, 16'h1234, 1'b1);
    read_hit(16'h0046, 16'h1234);
    do_write(16'h2000, 16'hBEEF, 1'b0);
    read_miss(16'h2000, 16'h7A5A);

    // Reset during the third fill cycle
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h3000;
    exp_q.push_back(16'h3000);
    exp_q.push_back(16'h3002);
    exp_q.push_back(16'h3004);
    step();
    step();
    step();
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_en", bus.mem_en, 0);
    chk("abort_stall", bus.stall, 0);
    chk("abort_hit_count", hit_count, 0);
    chk("abort_miss_count", miss_count, 0);
    exp_hit  = 0;
    exp_miss = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      @(negedge clk);
      if (c == 4) chk("late_rvalid_stall", bus.stall, 0);
    end
    step();
    read_miss(16'h0046, 16'h5A1C);

    // Hit counter saturation
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0046;
    @(negedge clk);
    chk("sat_rdata", bus.rdata, 16'h5A1C);
    repeat (65540) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("sat_hit_count", hit_count, 16'hFFFF);
    chk("sat_miss_count", miss_count, 1);

    chk("fill_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/assoc_cache_ctrl.md
Name: assoc_cache_ctrl

Overview:
- Parametrised set-associative cache controller: one CPU-side request channel, one pipelined multi-cycle memory channel.
- Holds the tag, valid and LRU state and the data array internally.
- Performs block fills on read misses; all writes are write-through, with no allocate on a write miss.
- Two instances (instruction and data) sit between the fetch/memory pipeline stages and a shared memory arbiter.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width (2 bytes per word).
- SETS, 64, number of sets (power of 2).
- WORDS, 8, words per block (power of 2, >=2).
- WAYS, 2, associativity; legal values 1 or 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  CPU request present
- req_write  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address (bit 0 ignored)
- req_wdata  in  DATA_W  store data
- stall  out  1  request cannot complete this cycle
- hit  out  1  request hit this cycle
- rdata  out  DATA_W  load data, valid when hit & !req_write
- mem_en  out  1  memory command valid
- mem_wr  out  1  command is a write
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  returned read data
- mem_rvalid  in  1  mem_rdata valid; returns arrive in issue order
- hit_count  out  16  saturating count of hits
- miss_count  out  16  saturating count of misses

Interface decision: single clock clk; reset rst is synchronous and active-high.

Behaviour:
- Address split:
  - OFF = log2(WORDS) + 1; word select = addr[OFF-1:1].
  - index = addr[OFF+log2(SETS)-1 : OFF].
  - tag = remaining upper bits.
- Reset:
  - All valid bits clear, LRU bits point to way 0, FSM in IDLE, counters 0.
  - stall=0, hit=0, rdata=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Hit detection is combinational in IDLE: a hit is a valid way whose tag matches.
- Read hit:
  - hit=1, stall=0, rdata driven from the hitting way in the same cycle.
  - LRU for the set is updated at the clock edge to point to the other way.
- Write hit:
  - Data word updated at the clock edge; LRU updated as for a read hit.
  - mem_en=1, mem_wr=1, mem_addr=req_addr, mem_wdata=req_wdata in the same cycle.
  - stall=0.
- Write miss:
  - Same single-cycle memory write; no allocate, cache unchanged, stall=0, hit=0, miss_count increments.
- Read miss in IDLE:
  - stall=1 combinationally; miss_count increments.
  - Victim choice: first invalid way, lowest index first; otherwise the LRU way.
  - FSM goes to FILL.
- FILL:
  - An issue counter i runs 0..WORDS-1, one read per cycle.
  - Each cycle: mem_en=1, mem_wr=0, mem_addr = {tag, index, i, 1'b0}.
  - Move to WAIT after i = WORDS-1 is issued.
- Receive counter (active in FILL and WAIT):
  - Each mem_rvalid writes mem_rdata into victim word r, then r increments.
  - mem_rvalid seen in IDLE is ignored.
- WAIT:
  - mem_en=0.
  - When the word with r = WORDS-1 is received: write the tag, set valid, set LRU to the other way, return to IDLE.
- Returning to IDLE:
  - stall stays 1 through FILL and WAIT, and drops in IDLE.
  - The held request is re-evaluated and hits in the first IDLE cycle; hit_count increments then.
- During FILL and WAIT: hit=0, rdata=0, and req_* changes are ignored (the CPU holds its request while stall=1).
- req_valid=0: no state change, stall=0, hit=0, mem_en=0.
- Reset mid-fill:
  - Abandons the fill and goes to IDLE with all state cleared.
  - Outputs take reset values from the following cycle; late mem_rvalid returns are ignored.
- WAYS=1: the LRU logic is absent and the victim is always way 0.
- Counters saturate at 0xFFFF.

Test Plan:
All scenarios use defaults and a memory model with 4-cycle read latency, mem[a] = a ^ 0x5A5A.
1. Reset, then read 0x0046:
   - stall=1; mem_addr 0x0040..0x004E on 8 consecutive cycles; WAIT until the 8th return.
   - Next cycle: hit=1, rdata=0x5A1C, stall=0; miss_count=1, hit_count=1.
2. After 1, read 0x0442 (same set 4, tag 1):
   - Way 1 is filled.
   - Then read 0x0842 (tag 2) evicts way 0 (the LRU way).
   - Re-reading 0x0040 misses; re-reading 0x0442 hits.
3. Write hit 0x0046 with data 0x1234:
   - Same cycle: mem_en=1, mem_wr=1, mem_addr=0x0046, stall=0.
   - A subsequent read of 0x0046 hits with rdata=0x1234.
4. Write miss to 0x2000 with 0xBEEF:
   - One memory write cycle, stall=0, hit=0.
   - A following read of 0x2000 misses.
5. Assert rst during the 3rd FILL cycle:
   - Next cycle mem_en=0 and stall=0.
   - Late mem_rvalid pulses are ignored; re-reading 0x0046 misses.
6. Drive 65536+ hits: hit_count holds at 0xFFFF.
